// File: rtl/img_mem_sched.sv
// Frame-load sequencer for the ROM -> filter -> RAM -> VGA image memory path.
// Define IMG_LIVE_VIEW_EN to let VGA reads run during LOAD and DRAIN.
module img_mem_sched #(
  parameter int IMG_BYTES = 38400,
  parameter int PIPE_LAT  = 3,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hold,
  input  logic        vga_req,
  input  logic [9:0]  vga_x,
  input  logic [8:0]  vga_y,
  output logic        mem_clr,
  output logic        rom_flag,
  output logic        ram_flag,
  output logic        vga_flag,
  output logic [18:0] vga_addr,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD, S_DRAIN, S_SHOW
  } st_e;

  localparam logic [16:0] NB = 17'(IMG_BYTES);
  localparam logic [9:0]  HA = 10'(H_ACTIVE);
  localparam logic [8:0]  VA = 9'(V_ACTIVE);

  st_e                 st_q, st_d;
  logic [16:0]         issue_q, issue_d, issue_nx;
  logic [16:0]         wr_q, wr_d, wr_nx;
  logic                rom_q, rom_d;
  logic [PIPE_LAT-1:0] dl_q, dl_d;
  logic [PIPE_LAT:0]   dl_sh;
  logic                vflag_q, vflag_d;
  logic [18:0]         vaddr_q, vaddr_d;
  logic                vga_en, vga_hit;

  // The delay line mirrors the filter latency so writes land in order.
  assign dl_sh    = {dl_q, rom_q};
  assign ram_flag = dl_q[PIPE_LAT-1];
  assign rom_flag = rom_q;
  assign mem_clr  = (st_q == S_CLR);
  assign busy     = (st_q == S_CLR) || (st_q == S_LOAD)
                 || (st_q == S_DRAIN);
  assign issue_nx = issue_q + {16'd0, rom_q};
  assign wr_nx    = wr_q + {16'd0, ram_flag};

  always_comb begin
    st_d    = st_q;
    issue_d = issue_q;
    wr_d    = wr_q;
    rom_d   = 1'b0;
    dl_d    = dl_sh[PIPE_LAT-1:0];
    done    = 1'b0;
    unique case (st_q)
      S_IDLE, S_SHOW: begin
        if (start) st_d = S_CLR;
      end
      S_CLR: begin
        issue_d = '0;
        wr_d    = '0;
        dl_d    = '0;
        rom_d   = !hold;
        st_d    = S_LOAD;
      end
      S_LOAD: begin
        issue_d = issue_nx;
        wr_d    = wr_nx;
        if (issue_nx == NB) st_d = S_DRAIN;
        else rom_d = !hold;
      end
      S_DRAIN: begin
        wr_d = wr_nx;
        if (wr_nx == NB) begin
          done = 1'b1;
          st_d = S_SHOW;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_comb begin
    unique case (st_q)
      S_LOAD:  state = 2'd1;
      S_DRAIN: state = 2'd2;
      S_SHOW:  state = 2'd3;
      default: state = 2'd0;
    endcase
  end

`ifdef IMG_LIVE_VIEW_EN
  assign vga_en = (st_q == S_LOAD) || (st_q == S_DRAIN)
               || (st_q == S_SHOW);
`else
  assign vga_en = (st_q == S_SHOW);
`endif

  // y*640 as (y<<9)+(y<<7); max 307199 fits in 19 bits.
  assign vga_hit = vga_en && vga_req && (vga_x < HA) && (vga_y < VA);

  always_comb begin
    vflag_d = vga_hit;
    vaddr_d = vaddr_q;
    if (vga_hit)
      vaddr_d = {1'b0, vga_y, 9'd0} + {3'd0, vga_y, 7'd0}
              + {9'd0, vga_x};
  end

  assign vga_flag = vflag_q;
  assign vga_addr = vaddr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= S_IDLE;
      issue_q <= '0;
      wr_q    <= '0;
      rom_q   <= 1'b0;
      dl_q    <= '0;
      vflag_q <= 1'b0;
      vaddr_q <= '0;
    end else begin
      st_q    <= st_d;
      issue_q <= issue_d;
      wr_q    <= wr_d;
      rom_q   <= rom_d;
      dl_q    <= dl_d;
      vflag_q <= vflag_d;
      vaddr_q <= vaddr_d;
    end
  end

endmodule

// File: tb/tb_img_mem_sched.sv
// Scoreboard bench for img_mem_sched: event-schedule model of a frame load,
// per-cycle control queue plus a VGA pixel queue popped on vga_flag.
module tb_img_mem_sched;

  localparam int NB  = 16;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic        vga_req = 1'b0;
  logic [9:0]  vga_x = '0;
  logic [8:0]  vga_y = '0;
  logic        mem_clr, rom_flag, ram_flag, vga_flag, busy, done;
  logic [18:0] vga_addr;
  logic [1:0]  state;

  always #5 clk = ~clk;

  img_mem_sched #(
    .IMG_BYTES(NB),
    .PIPE_LAT(LAT),
    .H_ACTIVE(640),
    .V_ACTIVE(480)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .hold(hold),
    .vga_req(vga_req),
    .vga_x(vga_x),
    .vga_y(vga_y),
    .mem_clr(mem_clr),
    .rom_flag(rom_flag),
    .ram_flag(ram_flag),
    .vga_flag(vga_flag),
    .vga_addr(vga_addr),
    .busy(busy),
    .done(done),
    .state(state)
  );

  typedef struct packed {
    logic        rom;
    logic        ram;
    logic        clr;
    logic        dn;
    logic        bsy;
    logic [1:0]  st;
    logic        vf;
    logic [18:0] va;
  } exp_t;

  exp_t ctrl_q[$];
  int   vga_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: a load is a clear cycle, then N issues gated by the
  // previous cycle's hold, each producing a write LAT cycles later.
  bit m_loading, m_show, m_rst_prev;
  int m_clr_at, m_done_at, m_issued, m_written, m_prev_st, m_addr;
  int m_due[$];

  function automatic void model_reset();
    m_loading = 0;
    m_show    = 0;
    m_clr_at  = -10;
    m_done_at = -1;
    m_issued  = 0;
    m_written = 0;
    m_prev_st = 0;
    m_addr    = 0;
    m_due.delete();
  endfunction

  function automatic void model_step(bit s, bit h, bit rq, int x, int y);
    int   n;
    bit   en;
    bit   in_load;
    exp_t e;
    n = cyc + 1;
    e = '0;
    in_load = 0;
    if (m_loading && m_done_at >= 0 && cyc > m_done_at) begin
      m_loading = 0;
      m_show    = 1;
    end
`ifdef IMG_LIVE_VIEW_EN
    en = (m_prev_st != 0);
`else
    en = (m_prev_st == 3);
`endif
    if (!m_loading && s) begin
      m_loading = 1;
      m_show    = 0;
      m_clr_at  = n;
      m_done_at = -1;
      m_issued  = 0;
      m_written = 0;
      m_due.delete();
    end
    e.clr = m_loading && (n == m_clr_at);
    if (m_loading && n > m_clr_at && m_issued < NB) begin
      in_load = 1;
      if (!h) begin
        e.rom = 1;
        m_issued++;
        m_due.push_back(n + LAT);
      end
    end
    if (m_due.size() > 0 && m_due[0] == n) begin
      void'(m_due.pop_front());
      e.ram = 1;
      m_written++;
      if (m_written == NB) begin
        e.dn = 1;
        m_done_at = n;
      end
    end
    if (m_loading) begin
      if (n == m_clr_at) e.st = 2'd0;
      else if (m_done_at >= 0 && n > m_done_at) e.st = 2'd3;
      else if (in_load) e.st = 2'd1;
      else e.st = 2'd2;
    end else begin
      e.st = m_show ? 2'd3 : 2'd0;
    end
    e.bsy = e.clr || e.st == 2'd1 || e.st == 2'd2;
    if (en && rq && x < 640 && y < 480) begin
      e.vf   = 1;
      m_addr = y * 640 + x;
      vga_q.push_back(m_addr);
    end
    e.va = 19'(m_addr);
    m_prev_st = e.st;
    ctrl_q.push_back(e);
  endfunction

  task automatic drive(input bit r, input bit s, input bit h,
                       input bit rq, input int x, input int y);
    @(posedge clk);
    #1;
    cyc++;
    rst     = r;
    start   = s;
    hold    = h;
    vga_req = rq;
    vga_x   = 10'(x);
    vga_y   = 9'(y);
    if (r) begin
      if (!m_rst_prev) begin
        ctrl_q.delete();
        vga_q.delete();
        model_reset();
        ctrl_q.push_back('0);
      end
      model_reset();
      ctrl_q.push_back('0);
    end else begin
      model_step(s, h, rq, x, y);
    end
    m_rst_prev = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd_cycle(input bit rnd_hold, input bit rnd_start);
    bit h, s, rq;
    int x, y;
    h  = rnd_hold ? 1'($urandom_range(0, 1)) : 1'b0;
    s  = rnd_start ? ($urandom_range(0, 7) == 0) : 1'b0;
    rq = 1'($urandom_range(0, 1));
    x  = $urandom_range(0, 700);
    y  = $urandom_range(0, 511);
    drive(0, s, h, rq, x, y);
  endtask

  task automatic run_to_show(input bit rnd, input string tag);
    int i;
    for (i = 0; i < 400 && !m_show; i++) begin
      if (rnd) rnd_cycle(1, 1);
      else drive(0, 0, 0, 0, 0, 0);
    end
    if (!m_show) begin
      errors++;
      $display("FAIL %s timeout: got no SHOW after %0d cycles, need SHOW",
               tag, i);
    end
  endtask

  task automatic run_to_issued(input int k, input bit toggle, input string tag);
    int i;
    for (i = 0; i < 400 && m_issued < k; i++)
      drive(0, 0, toggle ? 1'(i % 2) : 1'b0, 0, 0, 0);
    if (m_issued < k) begin
      errors++;
      $display("FAIL %s timeout: got %0d issues, need %0d", tag, m_issued, k);
    end
  endtask

  exp_t mon_e, mon_g;
  int   mon_a;

  always @(negedge clk) begin
    if (ctrl_q.size() > 0) begin
      mon_e = ctrl_q.pop_front();
      mon_g = {rom_flag, ram_flag, mem_clr, done, busy, state,
               vga_flag, vga_addr};
      checks++;
      if (mon_g !== mon_e) begin
        errors++;
        $display("FAIL ctrl cyc=%0d got rom=%b ram=%b clr=%b done=%b busy=%b st=%0d vf=%b va=%0d need rom=%b ram=%b clr=%b done=%b busy=%b st=%0d vf=%b va=%0d",
                 cyc, mon_g.rom, mon_g.ram, mon_g.clr, mon_g.dn, mon_g.bsy,
                 mon_g.st, mon_g.vf, mon_g.va, mon_e.rom, mon_e.ram,
                 mon_e.clr, mon_e.dn, mon_e.bsy, mon_e.st, mon_e.vf,
                 mon_e.va);
      end
    end
    if (vga_flag === 1'b1) begin
      checks++;
      if (vga_q.size() == 0) begin
        errors++;
        $display("FAIL vga cyc=%0d got pixel addr=%0d, need no pixel",
                 cyc, vga_addr);
      end else begin
        mon_a = vga_q.pop_front();
        if (vga_addr !== 19'(mon_a)) begin
          errors++;
          $display("FAIL vga_addr cyc=%0d got %0d need %0d",
                   cyc, vga_addr, mon_a);
        end
      end
    end
  end

  initial begin
    model_reset();
    m_rst_prev = 0;
    repeat (3) drive(1, 0, 0, 0, 0, 0);
    idle(2);

    // Plain load, no back-pressure
    drive(0, 1, 0, 0, 0, 0);
    run_to_show(0, "load_plain");
    idle(2);

    // Hold toggling 1-on/1-off
    drive(0, 1, 0, 0, 0, 0);
    run_to_issued(NB, 1, "load_hold");
    run_to_show(0, "load_hold");

    // VGA address corners in SHOW
    drive(0, 0, 0, 1, 639, 479);
    drive(0, 0, 0, 1, 640, 0);
    drive(0, 0, 0, 1, 0, 480);
    drive(0, 0, 0, 1, 5, 2);
    drive(0, 0, 0, 1, 0, 0);
    idle(2);

    // Reset after the 8th issue, then a full reload
    drive(0, 1, 0, 0, 0, 0);
    run_to_issued(8, 0, "rst_mid");
    drive(1, 0, 0, 1, 3, 3);
    drive(1, 0, 0, 0, 0, 0);
    idle(6);
    drive(0, 1, 0, 0, 0, 0);
    run_to_show(0, "reload");

    // Start pulses in LOAD and DRAIN are ignored; start in SHOW reloads
    drive(0, 1, 0, 1, 10, 10);
    drive(0, 0, 0, 1, 11, 10);
    for (int i = 0; i < 400 && !m_show; i++)
      drive(0, 1'(i % 2), 1'(i % 3 == 0), 1, i % 640, 7);
    if (!m_show) begin
      errors++;
      $display("FAIL start_ignore timeout: got no SHOW, need SHOW");
    end
    drive(0, 1, 0, 1, 1, 1);
    for (int i = 0; i < 400 && !m_show; i++)
      drive(0, 0, 0, 1, 100 + i, 20);
    idle(2);

    // Randomized loads with random hold, start and VGA traffic
    for (int k = 0; k < 6; k++) begin
      idle($urandom_range(0, 3));
      drive(0, 1, 1'($urandom_range(0, 1)), 0, 0, 0);
      run_to_show(1, "rand_load");
      for (int j = 0; j < 20; j++) rnd_cycle(0, 0);
    end

    idle(4);
    @(negedge clk);
    #1;
    checks++;
    if (vga_q.size() != 0) begin
      errors++;
      $display("FAIL vga_drain got %0d pending pixels, need 0", vga_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
